btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 86 ++++++++
 tb/tb_btn_debounce.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Multi-button debouncer: two-flop synchronizer, per-button debounce counter,
// press/release edge pulses and a single long-press pulse per hold.
module btn_debounce #(
    parameter int                 NUM_BTN         = 7,
    parameter int                 DEBOUNCE_CYCLES = 250000,
    parameter int                 LONG_CYCLES     = 25000000,
    parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = 7'b0000001
) (
    input  logic               clk_25mhz,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [NUM_BTN-1:0] r_level;
    logic [NUM_BTN-1:0] r_press;
    logic [NUM_BTN-1:0] r_release;
    logic [NUM_BTN-1:0] r_long;
    logic [DW-1:0]      r_db_cnt   [NUM_BTN];
    logic [HW-1:0]      r_hold_cnt [NUM_BTN];

    logic [NUM_BTN-1:0] w_sample;

    // Normalise polarity so every button reads 1 when pressed.
    assign w_sample = r_sync2 ^ ACTIVE_LOW_MASK;

    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            // Synchronizer parks at the released pin level so no edge is seen after reset.
            r_sync1   <= ACTIVE_LOW_MASK;
            r_sync2   <= ACTIVE_LOW_MASK;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_long    <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_db_cnt[i]   <= '0;
                r_hold_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_press[i]   <= 1'b0;
                r_release[i] <= 1'b0;

                if (w_sample[i] == r_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_level[i]   <= w_sample[i];
                    r_db_cnt[i]  <= '0;
                    r_press[i]   <= w_sample[i];
                    r_release[i] <= ~w_sample[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
                end

                // Saturation makes the LONG_CYCLES-1 match happen once per press.
                r_long[i] <= r_level[i] && (r_hold_cnt[i] == HOLD_LAST);
                if (!r_level[i]) begin
                    r_hold_cnt[i] <= '0;
                end else if (r_hold_cnt[i] != HOLD_MAX) begin
                    r_hold_cnt[i] <= r_hold_cnt[i] + HW'(1);
                end
            end
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign btn_long    = r_long;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed timing scenarios plus random bouncing,
// every cycle compared against a window-based behavioural model.
module tb_btn_debounce;

    localparam int         NB   = 7;
    localparam int         DB   = 4;
    localparam int         LC   = 20;
    localparam logic [6:0] MASK = 7'b0000001;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    logic          clk_25mhz = 1'b0;
    logic          rst_n     = 1'b0;
    logic [NB-1:0] btn       = MASK;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long;

    logic [NB-1:0] pressed = '0;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // ---------------- clock ----------------
    always #5 clk_25mhz = ~clk_25mhz;

    btn_debounce #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LC),
        .ACTIVE_LOW_MASK(MASK)
    ) dut (
        .clk_25mhz  (clk_25mhz),
        .rst_n      (rst_n),
        .btn        (btn),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    // ---------------- behavioural model ----------------
    // A button flips when the last DB sampled values all disagree with its level.
    logic [NB-1:0] m_p1 = '0;
    logic [NB-1:0] m_p2 = '0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] exp_level   = '0;
    logic [NB-1:0] exp_press   = '0;
    logic [NB-1:0] exp_release = '0;
    logic [NB-1:0] exp_long    = '0;
    int            age [NB];

    task automatic model_step();
        logic [NB-1:0] s_now;
        logic [NB-1:0] old_lvl;
        bit            all_diff;
        if (!rst_n) begin
            m_p1 = '0;
            m_p2 = '0;
            exp_q.delete();
            exp_level   = '0;
            exp_press   = '0;
            exp_release = '0;
            exp_long    = '0;
            for (int i = 0; i < NB; i++) age[i] = 0;
        end else begin
            s_now   = m_p2;
            m_p2    = m_p1;
            m_p1    = btn ^ MASK;
            old_lvl = exp_level;
            exp_q.push_back(s_now);
            if (exp_q.size() > DB) void'(exp_q.pop_front());
            exp_press   = '0;
            exp_release = '0;
            exp_long    = '0;
            for (int i = 0; i < NB; i++) begin
                if (old_lvl[i]) begin
                    if (age[i] <= LC) age[i]++;
                    if (age[i] == LC) exp_long[i] = 1'b1;
                end
                if (exp_q.size() == DB) begin
                    all_diff = 1'b1;
                    foreach (exp_q[k]) if (exp_q[k][i] == old_lvl[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        exp_level[i]   = ~old_lvl[i];
                        exp_press[i]   = ~old_lvl[i];
                        exp_release[i] = old_lvl[i];
                        if (!old_lvl[i]) age[i] = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NB; i++) age[i] = 0;
        forever begin
            @(posedge clk_25mhz);
            model_step();
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_25mhz);
            if (chk_en) begin
                check_vec("level",   btn_level,   exp_level);
                check_vec("press",   btn_press,   exp_press);
                check_vec("release", btn_release, exp_release);
                check_vec("long",    btn_long,    exp_long);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [NB-1:0] pick(input int kind);
        case (kind)
            K_PRESS:   return btn_press;
            K_RELEASE: return btn_release;
            default:   return btn_long;
        endcase
    endfunction

    task automatic set_btn(input int b, input logic v);
        @(negedge clk_25mhz);
        pressed[b] = v;
        btn = pressed ^ MASK;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_25mhz);
    endtask

    // Edge count (1 = first rising edge after the call) at which the pulse shows.
    task automatic wait_pulse(input int b, input int kind, input int budget, output int edges);
        logic [NB-1:0] v;
        edges = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk_25mhz);
            #1;
            v = pick(kind);
            if (v[b]) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int b, input int kind, input int ncyc, output int n);
        logic [NB-1:0] v;
        n = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk_25mhz);
            #1;
            v = pick(kind);
            if (v[b]) n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e;
        int n;

        rst_n = 1'b0;
        repeat (2) @(posedge clk_25mhz);
        #1;
        chk_en = 1'b1;
        check_vec("reset_level", btn_level, '0);
        check_vec("reset_press", btn_press | btn_release | btn_long, '0);
        @(negedge clk_25mhz);
        rst_n = 1'b1;
        idle(8);
        check_vec("btn0_idle_high_released", btn_level, '0);

        // Clean press and release
        set_btn(1, 1'b1);
        wait_pulse(1, K_PRESS, 30, e);
        check_int("clean_press_edge", e, 6);
        check_int("clean_press_level", int'(btn_level[1]), 1);
        idle(3);
        set_btn(1, 1'b0);
        wait_pulse(1, K_RELEASE, 30, e);
        check_int("clean_release_edge", e, 6);

        // Bounce: high 3, low 1, then held
        set_btn(2, 1'b1);
        idle(2);
        set_btn(2, 1'b0);
        set_btn(2, 1'b1);
        wait_pulse(2, K_PRESS, 30, e);
        check_int("bounce_press_edge", e, 6);
        idle(2);
        set_btn(2, 1'b0);
        idle(10);

        // Active-low button
        set_btn(0, 1'b1);
        wait_pulse(0, K_PRESS, 30, e);
        check_int("active_low_press_edge", e, 6);
        check_vec("active_low_raw", btn, 7'b0000000);
        idle(3);
        set_btn(0, 1'b0);
        idle(10);

        // Long press held 50 cycles
        set_btn(3, 1'b1);
        wait_pulse(3, K_PRESS, 30, e);
        check_int("long_press_edge", e, 6);
        wait_pulse(3, K_LONG, 40, e);
        check_int("long_after_press", e, LC);
        count_pulses(3, K_LONG, 50 - LC, n);
        check_int("long_no_repeat", n, 0);
        set_btn(3, 1'b0);
        wait_pulse(3, K_RELEASE, 30, e);
        check_int("long_release_edge", e, 6);
        idle(5);

        // Short press: release only
        set_btn(3, 1'b1);
        wait_pulse(3, K_PRESS, 30, e);
        count_pulses(3, K_LONG, 10, n);
        set_btn(3, 1'b0);
        wait_pulse(3, K_RELEASE, 30, e);
        check_int("short_release_edge", e, 6);
        count_pulses(3, K_LONG, 30, e);
        check_int("short_no_long", n + e, 0);

        // Reset mid-debounce with pin held
        set_btn(4, 1'b1);
        idle(3);
        rst_n = 1'b0;
        @(posedge clk_25mhz);
        #1;
        check_vec("midreset_outputs", btn_level | btn_press | btn_release | btn_long, '0);
        @(negedge clk_25mhz);
        rst_n = 1'b1;
        wait_pulse(4, K_PRESS, 30, e);
        check_int("after_reset_press_edge", e, 6);
        idle(3);
        set_btn(4, 1'b0);
        idle(10);

        // Simultaneous presses
        @(negedge clk_25mhz);
        pressed[5] = 1'b1;
        pressed[6] = 1'b1;
        btn = pressed ^ MASK;
        wait_pulse(5, K_PRESS, 30, e);
        check_int("simul_press5_edge", e, 6);
        check_int("simul_press6_same", int'(btn_press[6]), 1);
        @(negedge clk_25mhz);
        pressed = '0;
        btn = pressed ^ MASK;
        idle(12);

        // Random bouncing: a glitchy phase, then a slow phase with long holds
        for (int c = 0; c < 2400; c++) begin
            @(negedge clk_25mhz);
            rst_n = ($urandom_range(0, 399) != 0);
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, (c < 1200) ? 3 : 30) == 0) pressed[b] = ~pressed[b];
            end
            btn = pressed ^ MASK;
        end
        @(negedge clk_25mhz);
        rst_n = 1'b1;
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
